// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between the two byte sources, the bit-enable generator
// and the UART transmit scheduler. The scheduler takes the slave view.
interface uart_tx_sched_if;
  logic       txen;
  logic       req0;
  logic [7:0] data0;
  logic       req1;
  logic [7:0] data1;
  logic       gnt0;
  logic       gnt1;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       busy;

  modport master (
    output txen, req0, data0, req1, data1,
    input  gnt0, gnt1, tx_data, tx_load, busy
  );

  modport slave (
    input  txen, req0, data0, req1, data1,
    output gnt0, gnt1, tx_data, tx_load, busy
  );
endinterface

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: round-robin share of one tx block between two
// byte sources. Frame end is found by counting txen bit ticks, so the tx
// block needs no busy output.
// Optional inter-frame gap: define UART_TX_GAP_EN to hold off the next
// grant for GAP_TICKS extra bit times after every frame.
//
// state | meaning
// IDLE  | arbitrate; grant registers gntN, tx_data, busy and the rr pointer
// LOAD  | grant cycle; tx_load issues on the following cycle, counter cleared
// WAIT  | count FRAME_TICKS txen ticks (the tx_load cycle itself is not counted)
// GAP   | count GAP_TICKS idle ticks (UART_TX_GAP_EN builds only)
module uart_tx_sched #(
  parameter int FRAME_TICKS = 10,
  parameter int GAP_TICKS   = 2,
  parameter int CW          = 4
) (
  input  logic           clk,
  input  logic           n_rst,
  uart_tx_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam int            TICK_MAX   = (FRAME_TICKS > GAP_TICKS) ? FRAME_TICKS : GAP_TICKS;
  localparam logic [CW-1:0] TICK_SAT   = CW'(TICK_MAX);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_TICKS - 1);
`ifdef UART_TX_GAP_EN
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_TICKS - 1);
  localparam state_t        FRAME_EXIT = S_GAP;
`else
  localparam state_t        FRAME_EXIT = S_IDLE;
`endif

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_grant0;
  logic          w_grant1;
  logic          w_cnt_clr;
  logic          w_cnt_inc;
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_tx_load;
  logic [7:0]    r_tx_data;
  logic          r_busy;
  logic          r_rr;
  logic [CW-1:0] r_cnt;

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state, arbitration and tick-counter control.
  always_comb begin
    w_state_nxt = r_state;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // r_rr=0 favours source 0 when both are requesting.
        if (bus.req0 && (!bus.req1 || !r_rr)) begin
          w_grant0    = 1'b1;
          w_state_nxt = S_LOAD;
        end else if (bus.req1) begin
          w_grant1    = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A tick coinciding with tx_load belongs to no bit yet.
        if (bus.txen && !r_tx_load) begin
          if (r_cnt == FRAME_LAST) begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = FRAME_EXIT;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
`ifdef UART_TX_GAP_EN
      S_GAP: begin
        if (bus.txen) begin
          if (r_cnt == GAP_LAST) begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs, latched byte, rr pointer and tick counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_tx_load <= 1'b0;
      r_tx_data <= 8'h00;
      r_busy    <= 1'b0;
      r_rr      <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_gnt0    <= w_grant0;
      r_gnt1    <= w_grant1;
      r_tx_load <= (r_state == S_LOAD);
      r_busy    <= (w_state_nxt != S_IDLE);
      if (w_grant0) begin
        r_tx_data <= bus.data0;
        r_rr      <= 1'b1;
      end else if (w_grant1) begin
        r_tx_data <= bus.data1;
        r_rr      <= 1'b0;
      end
      // Saturate at the largest terminal count so a bad parameter set cannot wrap.
      if (w_cnt_clr)                           r_cnt <= '0;
      else if (w_cnt_inc && r_cnt != TICK_SAT) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.gnt0    = r_gnt0;
  assign bus.gnt1    = r_gnt1;
  assign bus.tx_load = r_tx_load;
  assign bus.tx_data = r_tx_data;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a transaction
// model (grant -> load -> N counted bit ticks -> free).
module tb_uart_tx_sched;
  localparam int FRAME_TICKS = 10;
`ifdef UART_TX_GAP_EN
  localparam int GAP_TICKS = 2;
`else
  localparam int GAP_TICKS = 0;
`endif
  localparam int BUSY_TICKS = FRAME_TICKS + GAP_TICKS;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  uart_tx_sched_if bus();

  uart_tx_sched #(.FRAME_TICKS(10), .GAP_TICKS(2), .CW(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int cyc      = 0;
  bit txen_rand = 1'b0;

  logic       req_v     [2];
  logic [7:0] dat_v     [2];
  bit         drop_pend [2];
  int         src_mode  [2];   // 0 manual, 1 always re-request, 2 random

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_free = 1'b1;
  bit         m_rr   = 1'b0;
  int         m_age  = 0;
  int         m_left = 0;
  bit         e_gnt0 = 1'b0, e_gnt1 = 1'b0, e_load = 1'b0, e_busy = 1'b0;
  logic [7:0] e_data = 8'h00;

  always @(posedge clk or negedge n_rst) begin : model
    bit free, rr, g0, g1, ld, bsy, pick1;
    int age, left;
    logic [7:0] dat;
    if (!n_rst) begin
      m_free <= 1'b1; m_rr <= 1'b0; m_age <= 0; m_left <= 0;
      e_gnt0 <= 1'b0; e_gnt1 <= 1'b0; e_load <= 1'b0; e_busy <= 1'b0; e_data <= 8'h00;
    end else begin
      free = m_free; rr = m_rr; age = m_age; left = m_left;
      dat = e_data; bsy = e_busy; g0 = 1'b0; g1 = 1'b0; ld = 1'b0;
      if (free) begin
        if (bus.req0 || bus.req1) begin
          pick1 = bus.req1 && (!bus.req0 || rr);
          if (pick1) begin g1 = 1'b1; dat = bus.data1; rr = 1'b0; end
          else       begin g0 = 1'b1; dat = bus.data0; rr = 1'b1; end
          free = 1'b0; age = 0; left = BUSY_TICKS; bsy = 1'b1;
        end
      end else begin
        // age 0 = grant cycle, age 1 = load cycle; ticks count from age 2 on
        if (age >= 2 && bus.txen) begin
          left--;
          if (left == 0) begin free = 1'b1; bsy = 1'b0; end
        end
        age++;
        if (age == 1) ld = 1'b1;
      end
      m_free <= free; m_rr <= rr; m_age <= age; m_left <= left;
      e_gnt0 <= g0; e_gnt1 <= g1; e_load <= ld; e_busy <= bsy; e_data <= dat;
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      chk("gnt0",    bus.gnt0,    e_gnt0);
      chk("gnt1",    bus.gnt1,    e_gnt1);
      chk("tx_load", bus.tx_load, e_load);
      chk("busy",    bus.busy,    e_busy);
      chk("tx_data", bus.tx_data, e_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive();
    bus.req0  = req_v[0];
    bus.data0 = dat_v[0];
    bus.req1  = req_v[1];
    bus.data1 = dat_v[1];
  endtask

  task automatic set_req(input int s, input logic r, input logic [7:0] d);
    req_v[s] = r;
    dat_v[s] = d;
    drive();
  endtask

  task automatic tick();
    bit g [2];
    bit drp;
    @(posedge clk);
    #2;
    cyc++;
    bus.txen = txen_rand ? ($urandom_range(2) == 0) : ((cyc % 4) == 0);
    g[0] = bus.gnt0;
    g[1] = bus.gnt1;
    for (int s = 0; s < 2; s++) begin
      drp = 1'b0;
      if (drop_pend[s]) begin req_v[s] = 1'b0; drop_pend[s] = 1'b0; drp = 1'b1; end
      if (g[s]) drop_pend[s] = 1'b1;
      if (!req_v[s] && !drp && !g[s]) begin
        if (src_mode[s] == 1) req_v[s] = 1'b1;
        else if (src_mode[s] == 2 && $urandom_range(3) == 0) begin
          req_v[s] = 1'b1;
          dat_v[s] = 8'($urandom);
        end
      end
    end
    drive();
  endtask

  task automatic wait_load(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.tx_load) begin ok = 1'b1; return; end
    end
  endtask

  // Called in the tx_load cycle; counts ticks seen while busy stays high.
  task automatic count_frame(output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!bus.busy) return;
      if (bus.txen) n++;
    end
    n = -1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!bus.busy) return;
    end
    chk("idle_timeout", 1, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    bit ok;
    int n, k, n_loads, between;
    logic [7:0] seq [4];

    for (int s = 0; s < 2; s++) begin
      req_v[s] = 1'b0; dat_v[s] = 8'h00; drop_pend[s] = 1'b0; src_mode[s] = 0;
    end
    bus.txen = 1'b0;
    drive();
    #1 n_rst = 1'b0;
    chk_en = 1'b1;

    // Reset held with a request pending
    set_req(0, 1'b1, 8'h41);
    for (int i = 0; i < 4; i++) tick();
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_load", bus.tx_load, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_data", bus.tx_data, 8'h00);
    n_rst = 1'b1;
    tick();
    chk("rel_gnt0", bus.gnt0, 1);
    chk("rel_busy", bus.busy, 1);
    chk("rel_load_early", bus.tx_load, 0);
    tick();
    chk("rel_load", bus.tx_load, 1);
    chk("rel_gnt0_once", bus.gnt0, 0);
    chk("rel_data", bus.tx_data, 8'h41);
    count_frame(n);
    chk("single_ticks", n, BUSY_TICKS);
    chk("data_held", bus.tx_data, 8'h41);

    // Contention: both sources request continuously from a fresh reset
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    set_req(0, 1'b1, 8'h31);
    set_req(1, 1'b1, 8'h32);
    src_mode[0] = 1; src_mode[1] = 1;
    n_loads = 0; between = 0;
    for (int i = 0; i < 4; i++) seq[i] = 8'h00;
    for (int i = 0; i < 2000 && n_loads < 4; i++) begin
      tick();
      if (bus.tx_load) begin
        seq[n_loads] = bus.tx_data;
        if (n_loads > 0) chk("load_spacing", between, BUSY_TICKS);
        n_loads++;
        between = 0;
      end else if (bus.txen) begin
        between++;
      end
    end
    chk("contention_loads", n_loads, 4);
    for (int i = 0; i < 4; i++) chk("rr_order", seq[i], (i % 2 == 0) ? 8'h31 : 8'h32);
    src_mode[0] = 0; src_mode[1] = 0;
    set_req(0, 1'b0, 8'h00);
    set_req(1, 1'b0, 8'h00);
    wait_idle();
    tick();
    wait_idle();

    // Request arriving mid-frame waits for the frame end
    set_req(0, 1'b1, 8'h55);
    wait_load(ok);
    chk("busyreq_load", ok, 1);
    k = 0;
    for (int i = 0; i < 100 && k < 4; i++) begin
      tick();
      if (bus.txen) k++;
    end
    set_req(1, 1'b1, 8'hAA);
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!bus.busy) break;
    end
    chk("busyreq_fall_gnt1", bus.gnt1, 0);
    chk("busyreq_fall_busy", bus.busy, 0);
    tick();
    chk("busyreq_gnt1", bus.gnt1, 1);
    chk("busyreq_data", bus.tx_data, 8'hAA);
    wait_idle();

    // Reset in the middle of a frame
    set_req(0, 1'b1, 8'h77);
    wait_load(ok);
    chk("midrst_load", ok, 1);
    k = 0;
    for (int i = 0; i < 100 && k < 5; i++) begin
      tick();
      if (bus.txen) k++;
    end
    chk("midrst_busy_before", bus.busy, 1);
    n_rst = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_load_low", bus.tx_load, 0);
    chk("midrst_data", bus.tx_data, 8'h00);
    tick();
    n_rst = 1'b1;
    set_req(1, 1'b1, 8'h66);
    wait_load(ok);
    chk("midrst_reload", ok, 1);
    chk("midrst_new_data", bus.tx_data, 8'h66);
    count_frame(n);
    chk("midrst_ticks", n, BUSY_TICKS);

    // Randomized traffic and bit ticks
    txen_rand = 1'b1;
    src_mode[0] = 2; src_mode[1] = 2;
    for (int i = 0; i < 3000; i++) tick();
    src_mode[0] = 0; src_mode[1] = 0;
    for (int i = 0; i < 20; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
